// File: rtl/fft_out_collector.sv
// fft_out_collector: collects FFT output samples (arbitrary order) into a
// frame buffer, then drains them in natural order on a valid/ready stream.
// Optional feature macro: COLLECTOR_WRITE_CHECK_EN (written-index bitmap
// driving the miss and dup_err outputs; tied low when undefined).
//
// Stream handshake: a sample transfers on a rising edge where out_valid=1 and
// out_ready=1; while out_valid=1 and out_ready=0, out_re/out_im/out_last/miss
// hold stable, and out_valid never drops without a transfer (except reset).
module fft_out_collector #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 1200,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             do_en,
    input  logic [AW-1:0]    address,
    input  logic [WIDTH-1:0] do_re,
    input  logic [WIDTH-1:0] do_im,
    input  logic             Finish,
    input  logic [AW-1:0]    frame_len,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic             addr_err,
    output logic             overrun,
    output logic             miss,
    output logic             dup_err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_COLLECT = 2'd1, S_DRAIN = 2'd2} state_t;

    localparam logic [AW-1:0] DEPTH_AW = AW'(DEPTH);

    state_t                 state_q, state_d;
    logic [AW-1:0]          len_q, len_d;
    logic [AW-1:0]          issue_q, issue_d;
    logic [AW-1:0]          out_idx_q, out_idx_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic                   addr_err_q, addr_err_d;
    logic                   overrun_q, overrun_d;
    logic [2*WIDTH-1:0]     mem_q [DEPTH];
    logic [2*WIDTH-1:0]     rd_data_q;
    logic                   wr_en;
    logic [AW-1:0]          rd_addr;
    logic [AW-1:0]          frame_eff;
    logic                   take;
    logic                   load;
    logic                   miss_int;

    // Next-state, write enable and drain read-address selection.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issue_d     = issue_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        addr_err_d  = addr_err_q;
        overrun_d   = overrun_q;
        wr_en       = 1'b0;
        rd_addr     = out_idx_q;
        frame_eff   = (frame_len == '0) ? DEPTH_AW : frame_len;
        take        = out_valid_q && out_ready;
        load        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (do_en) begin
                    len_d   = frame_eff;
                    state_d = S_COLLECT;
                    if (address < frame_eff) wr_en = 1'b1;
                    else                     addr_err_d = 1'b1;
                end
            end
            S_COLLECT: begin
                if (do_en) begin
                    if (address < len_q) wr_en = 1'b1;
                    else                 addr_err_d = 1'b1;
                end
                if (Finish) begin
                    state_d = S_DRAIN;
                    issue_d = '0;
                end
            end
            S_DRAIN: begin
                if (do_en) overrun_d = 1'b1;
                // Slot frees when empty or being consumed; a stalled slot
                // re-reads its own index so the registered data stays put.
                load = !out_valid_q || take;
                if (take && out_last_q) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else if (load) begin
                    if (issue_q < len_q) begin
                        rd_addr     = issue_q;
                        out_valid_d = 1'b1;
                        out_idx_d   = issue_q;
                        out_last_d  = (issue_q == len_q - AW'(1));
                        issue_d     = issue_q + AW'(1);
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            issue_q     <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            addr_err_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issue_q     <= issue_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            addr_err_q  <= addr_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Frame buffer: no reset so it maps to block RAM; read is registered.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[address] <= {do_re, do_im};
        rd_data_q <= mem_q[rd_addr];
    end

`ifdef COLLECTOR_WRITE_CHECK_EN
    logic [DEPTH-1:0] written_q, written_d;
    logic             dup_err_q, dup_err_d;
    logic             miss_q;

    // Written-index bitmap, cleared when a new frame starts.
    always_comb begin
        written_d = written_q;
        dup_err_d = dup_err_q;
        if (state_q == S_IDLE && do_en) written_d = '0;
        if (wr_en) begin
            if (state_q == S_COLLECT && written_q[address]) dup_err_d = 1'b1;
            written_d[address] = 1'b1;
        end
    end

    // Bitmap and sticky duplicate flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            written_q <= '0;
            dup_err_q <= 1'b0;
        end else begin
            written_q <= written_d;
            dup_err_q <= dup_err_d;
        end
    end

    // Miss flag tracks the registered read just like the data.
    always_ff @(posedge clk) begin
        miss_q <= !written_q[rd_addr];
    end

    assign miss_int = out_valid_q && miss_q;
    assign dup_err  = dup_err_q;
`else
    assign miss_int = 1'b0;
    assign dup_err  = 1'b0;
`endif

    assign miss      = miss_int;
    assign out_re    = (out_valid_q && !miss_int) ? rd_data_q[2*WIDTH-1:WIDTH] : '0;
    assign out_im    = (out_valid_q && !miss_int) ? rd_data_q[WIDTH-1:0]       : '0;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != S_IDLE);
    assign addr_err  = addr_err_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fft_out_collector.sv
// Bench for fft_out_collector: directed frames, expected samples queued when
// Finish is issued, a negedge monitor pops and compares every handshake.
module tb_fft_out_collector;

    localparam int W  = 18;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          do_en = 1'b0;
    logic [AW-1:0] address = '0;
    logic [W-1:0]  do_re = '0;
    logic [W-1:0]  do_im = '0;
    logic          Finish = 1'b0;
    logic [AW-1:0] frame_len = '0;
    logic [W-1:0]  out_re, out_im;
    logic          out_valid, out_last;
    logic          out_ready = 1'b1;
    logic          busy, addr_err, overrun, miss, dup_err;
    logic [1:0]    dbg_state;

    fft_out_collector dut (
        .clk(clk), .reset(reset), .do_en(do_en), .address(address),
        .do_re(do_re), .do_im(do_im), .Finish(Finish), .frame_len(frame_len),
        .out_re(out_re), .out_im(out_im), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .busy(busy),
        .addr_err(addr_err), .overrun(overrun), .miss(miss),
        .dup_err(dup_err), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int hs_count = 0;
    int rdy_mode = 0;
    int cur_len = 0;

    logic [2*W+1:0] exp_q [$];
    logic [W-1:0]   m_re [32];
    logic [W-1:0]   m_im [32];
    logic           wr_mask [32];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = stalled.
    initial begin
        logic [3:0] pat;
        int pi;
        pat = 4'b1001;
        pi = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = pat[pi];
                    pi = (pi + 1) % 4;
                end
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard: every handshake pops one expected sample.
    initial begin
        logic [2*W+1:0] got, held, exp;
        logic stall_pending;
        stall_pending = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                got = {miss, out_last, out_re, out_im};
                if (stall_pending) chk("stall_stable", 64'(got), 64'(held));
                if (out_ready) begin
                    hs_count++;
                    stall_pending = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 64'(got), 64'h0);
                        if (got == '0) begin
                            n_err++;
                            $display("FAIL unexpected_out got=zero sample expected=none");
                        end
                    end else begin
                        exp = exp_q.pop_front();
                        chk("sample", 64'(got), 64'(exp));
                    end
                end else begin
                    held = got;
                    stall_pending = 1'b1;
                end
            end else begin
                stall_pending = 1'b0;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Drive one input cycle, then release the strobes.
    task automatic put(input bit en, input int a, input logic [W-1:0] re,
                       input logic [W-1:0] im, input bit fin);
        do_en   = en;
        address = AW'(a);
        do_re   = re;
        do_im   = im;
        Finish  = fin;
        @(posedge clk);
        #1;
        do_en  = 1'b0;
        Finish = 1'b0;
    endtask

    task automatic begin_frame(input int len);
        cur_len   = len;
        frame_len = AW'(len);
        for (int i = 0; i < 32; i++) wr_mask[i] = 1'b0;
    endtask

    task automatic push_frame();
        logic [2*W+1:0] e;
        for (int i = 0; i < cur_len; i++) begin
`ifdef COLLECTOR_WRITE_CHECK_EN
            if (!wr_mask[i]) e = {1'b1, (i == cur_len - 1), {W{1'b0}}, {W{1'b0}}};
            else             e = {1'b0, (i == cur_len - 1), m_re[i], m_im[i]};
`else
            e = {1'b0, (i == cur_len - 1), m_re[i], m_im[i]};
`endif
            exp_q.push_back(e);
        end
    endtask

    // Valid write in a frame: update the model, push expectations on Finish.
    task automatic wr(input int a, input logic [W-1:0] re, input logic [W-1:0] im, input bit fin);
        m_re[a] = re;
        m_im[a] = im;
        wr_mask[a] = 1'b1;
        put(1'b1, a, re, im, fin);
        if (fin) push_frame();
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(k < 300), 64'd1);
        chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Writes a full frame in blocks of 8 with scrambled order inside each block.
    task automatic write_blocks(input int len, input int base, input bit fin_last);
        int perm [8];
        int a;
        perm = '{3, 0, 7, 5, 1, 6, 2, 4};
        for (int b = 0; b < len / 8; b++) begin
            for (int j = 0; j < 8; j++) begin
                a = b * 8 + perm[j];
                wr(a, W'(base + a * 37), W'(262143 - a * 11 - base),
                   fin_last && (b == len / 8 - 1) && (j == 7));
            end
        end
    endtask

    initial begin
        int k, run, h0;
        for (int i = 0; i < 32; i++) begin
            m_re[i] = '0;
            m_im[i] = '0;
            wr_mask[i] = 1'b0;
        end

        // Reset state
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_re", 64'(out_re), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_flags", 64'({addr_err, overrun, miss, dup_err}), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);

        // frame_len=0 means DEPTH: 1199 is legal, 1200 is out of range
        frame_len = '0;
        put(1'b1, 1199, W'(1), W'(2), 1'b0);
        chk("len0_busy", 64'(busy), 64'd1);
        chk("len0_addr1199_ok", 64'(addr_err), 64'd0);
        put(1'b1, 1200, W'(1), W'(2), 1'b0);
        chk("len0_addr1200_err", 64'(addr_err), 64'd1);
        do_reset();

        // 24 samples, three scrambled blocks, full-rate drain
        begin_frame(24);
        rdy_mode = 0;
        write_blocks(24, 100, 1'b1);
        chk("drain_busy", 64'(busy), 64'd1);
        k = 0;
        while (!out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("first_valid_latency_ok", 64'(k <= 2), 64'd1);
        run = 0;
        while (out_valid && run < 100) begin
            run++;
            @(negedge clk);
        end
        chk("burst_len", 64'(run), 64'd24);
        chk("after_last_idle", 64'({busy, out_valid}), 64'd0);
        wait_idle("t1_done");

        // 8 samples, ready toggling 1,0,0,1
        begin_frame(8);
        for (int i = 0; i < 8; i++) wr(i, W'(5000 + i * 3), W'(7000 - i * 5), i == 7);
        h0 = hs_count;
        rdy_mode = 1;
        wait_idle("t2_done");
        chk("t2_handshakes", 64'(hs_count - h0), 64'd8);
        rdy_mode = 0;

        // Out-of-range address drops sample, addr_err sticky
        begin_frame(8);
        chk("t3_addr_err_before", 64'(addr_err), 64'd0);
        for (int i = 0; i < 4; i++) wr(i, W'(9000 + i), W'(9100 + i), 1'b0);
        put(1'b1, 9, W'(12345), W'(23456), 1'b0);
        chk("t3_addr_err_set", 64'(addr_err), 64'd1);
        for (int i = 4; i < 8; i++) wr(i, W'(9000 + i), W'(9100 + i), i == 7);
        wait_idle("t3_done");
        chk("t3_addr_err_held", 64'(addr_err), 64'd1);

        // Write attempt during a stalled drain
        begin_frame(8);
        rdy_mode = 2;
        for (int i = 0; i < 8; i++) wr(i, W'(11000 + i * 7), W'(13000 + i * 9), i == 7);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_overrun_before", 64'(overrun), 64'd0);
        put(1'b1, 2, W'(77), W'(88), 1'b0);
        chk("t4_overrun_set", 64'(overrun), 64'd1);
        rdy_mode = 0;
        wait_idle("t4_done");

        // Reset at the 4th handshake, then a fresh 24-sample frame
        begin_frame(24);
        write_blocks(24, 300, 1'b1);
        h0 = hs_count;
        k = 0;
        while (hs_count < h0 + 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t5_reached_3rd", 64'(k < 100), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_flags", 64'({addr_err, overrun, dup_err, out_last}), 64'd0);
        chk("t5_rst_data", 64'({out_re, out_im}), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("t5_no_valid_after", 64'(out_valid), 64'd0);
        begin_frame(24);
        write_blocks(24, 600, 1'b1);
        wait_idle("t5_done");

        // Skip index 3, write index 5 twice
        begin_frame(8);
        wr(0, W'(21000), W'(21500), 1'b0);
        wr(1, W'(21001), W'(21501), 1'b0);
        wr(2, W'(21002), W'(21502), 1'b0);
        wr(5, W'(21005), W'(21505), 1'b0);
        chk("t6_dup_before", 64'(dup_err), 64'd0);
        wr(4, W'(21004), W'(21504), 1'b0);
        wr(6, W'(21006), W'(21506), 1'b0);
        wr(7, W'(21007), W'(21507), 1'b0);
        wr(5, W'(25555), W'(26666), 1'b1);
`ifdef COLLECTOR_WRITE_CHECK_EN
        chk("t6_dup_err", 64'(dup_err), 64'd1);
`else
        chk("t6_dup_err", 64'(dup_err), 64'd0);
`endif
        wait_idle("t6_done");
        chk("t6_miss_idle", 64'(miss), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/fft_out_collector.md
FFT_OUT_COLLECTOR -- requirements
Module: fft_out_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 18, sample component width (two's complement).
REQ-002 SHALL have parameter DEPTH, default 1200, maximum frame length in samples.
REQ-003 SHALL have parameter AW, default 11, address width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port do_en  input  1  FFT output sample valid this cycle.
REQ-007 SHALL have port address  input  AW  natural-order bin index of current sample.
REQ-008 SHALL have port do_re / do_im  input  WIDTH each  FFT output sample.
REQ-009 SHALL have port Finish  input  1  one-cycle pulse: FFT frame complete.
REQ-010 SHALL have port frame_len  input  AW  samples per frame (1..DEPTH), sampled per REQ-014.
REQ-011 SHALL have port out_re / out_im  output  WIDTH each  natural-order output sample.
REQ-012 SHALL have port out_valid, out_last  output  1 each, and out_ready  input  1: valid/ready stream.
REQ-013 SHALL have ports busy, addr_err, overrun  output  1 each  status; the two _err flags are sticky.

Function
REQ-014 States IDLE, COLLECT, DRAIN; in IDLE, do_en=1 latches frame_len, writes the sample, and moves to COLLECT.
REQ-015 In IDLE/COLLECT, do_en=1 with address<latched len SHALL write {do_re,do_im} to mem[address]; a later write to the same address overwrites.
REQ-016 address>=latched len with do_en=1 SHALL drop the sample and set addr_err.
REQ-017 Finish=1 in COLLECT SHALL enter DRAIN next cycle; Finish in IDLE or DRAIN is ignored.
REQ-018 do_en=1 in DRAIN SHALL drop the sample and set overrun; the memory is not modified.
REQ-019 DRAIN reads indices 0..len-1 in ascending order; the first out_valid SHALL assert no later than 2 cycles after DRAIN entry.
REQ-020 While out_valid=1 and out_ready=0, out_re/out_im/out_last SHALL hold stable.
REQ-021 With out_ready held 1, the block SHALL sustain one sample per cycle (no bubbles after the first).
REQ-022 out_last=1 only with index len-1; a handshake on it SHALL return to IDLE next cycle with out_valid=0.
REQ-023 A latched len of 0 SHALL be treated as DEPTH.
REQ-024 busy=1 in COLLECT and DRAIN, 0 in IDLE.
REQ-025 do_en and Finish in the same COLLECT cycle: the sample SHALL be written and then DRAIN entered, and the sample SHALL appear in the output.

Reset
REQ-026 reset SHALL force IDLE and out_valid=0, out_last=0, out_re=out_im=0, busy=0, addr_err=0, overrun=0, regardless of state.
REQ-027 Memory contents SHALL NOT be cleared by reset; an unwritten address drains stale data unless REQ-029 applies.
REQ-028 Reset mid-DRAIN SHALL abandon the frame; no further out_valid until a new frame completes.

Configuration
REQ-029 With macro COLLECTOR_WRITE_CHECK_EN defined: a DEPTH-bit written bitmap, cleared on IDLE->COLLECT and on reset; in DRAIN, unwritten indices output 0 with output miss=1; a second write to an already-written index sets sticky output dup_err.
REQ-030 Without COLLECTOR_WRITE_CHECK_EN: no bitmap; miss and dup_err ports exist and are tied 0.

Verification
REQ-031 len=24; 3 blocks of 8 samples at addresses 0-7, 8-15, 16-23 (out of order within each block); Finish; out_ready=1 -> 24 consecutive out_valid cycles in order 0..23, out_last on index 23, then IDLE.
REQ-032 len=8; out_ready toggled 1,0,0,1 repeatedly -> every sample seen exactly once; data stable while stalled; 8 handshakes total.
REQ-033 len=8; do_en with address=9 -> sample dropped, addr_err=1 and held until reset; the other 8 samples drain correctly.
REQ-034 do_en during DRAIN -> overrun=1; drained values unchanged.
REQ-035 reset asserted at the 4th DRAIN handshake -> next cycle out_valid=0, busy=0, all flags 0; a new 24-sample frame then drains correctly.
REQ-036 With COLLECTOR_WRITE_CHECK_EN: len=8, address 3 never written, address 5 written twice -> index 3 out 0 with miss=1, index 5 holds the second value, dup_err=1; without the macro: miss=0, dup_err=0.
